mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter that multiplexes NREQ requesters onto a dual-port SRAM.
// Read responses are routed back to the originating requester one cycle after the grant.
module mem_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NREQ-1:0]      REQ_VALID,
    output logic [NREQ-1:0]      REQ_READY,
    input  logic [NREQ-1:0]      REQ_WE,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*DW-1:0]   REQ_D,
    input  logic [NREQ*DW-1:0]   REQ_WEM,
    output logic [NREQ-1:0]      RSP_VALID,
    output logic [NREQ*DW-1:0]   RSP_Q,
    output logic [AW-1:0]        A0,
    output logic [AW-1:0]        A1,
    output logic [DW-1:0]        D0,
    output logic [DW-1:0]        D1,
    output logic [DW-1:0]        WEM0,
    output logic [DW-1:0]        WEM1,
    output logic                 WE0,
    output logic                 WE1,
    output logic                 CE0,
    output logic                 CE1,
    input  logic [DW-1:0]        Q0,
    input  logic [DW-1:0]        Q1
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] id0, id1;
    logic          gnt0, gnt1;
    logic          vld0_p1, vld1_p1;
    logic [PW-1:0] id0_p1, id1_p1;

    // Modular increment that also wraps correctly when NREQ is not a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Stage p0: scan from ptr, first valid takes port 0, next non-conflicting valid takes port 1.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        id0  = '0;
        id1  = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(ptr, k);
            if (RSTN && REQ_VALID[cand]) begin
                if (!gnt0) begin
                    gnt0 = 1'b1;
                    id0  = cand;
                end else if (!gnt1 &&
                             !((REQ_ADDR[int'(cand)*AW +: AW] == REQ_ADDR[int'(id0)*AW +: AW]) &&
                               (REQ_WE[cand] || REQ_WE[id0]))) begin
                    gnt1 = 1'b1;
                    id1  = cand;
                end
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (gnt0) REQ_READY[id0] = 1'b1;
        if (gnt1) REQ_READY[id1] = 1'b1;
    end

    always_comb begin
        CE0  = gnt0;
        WE0  = gnt0 && REQ_WE[id0];
        A0   = gnt0 ? REQ_ADDR[int'(id0)*AW +: AW] : '0;
        D0   = gnt0 ? REQ_D[int'(id0)*DW +: DW]    : '0;
        WEM0 = gnt0 ? REQ_WEM[int'(id0)*DW +: DW]  : '0;
        CE1  = gnt1;
        WE1  = gnt1 && REQ_WE[id1];
        A1   = gnt1 ? REQ_ADDR[int'(id1)*AW +: AW] : '0;
        D1   = gnt1 ? REQ_D[int'(id1)*DW +: DW]    : '0;
        WEM1 = gnt1 ? REQ_WEM[int'(id1)*DW +: DW]  : '0;
    end

    // Stage p0 -> p1: pointer advance and per-port read tags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr     <= '0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
            id0_p1  <= '0;
            id1_p1  <= '0;
        end else begin
            if (gnt0) ptr <= wrap_add(gnt1 ? id1 : id0, 1);
            vld0_p1 <= gnt0 && !REQ_WE[id0];
            vld1_p1 <= gnt1 && !REQ_WE[id1];
            id0_p1  <= id0;
            id1_p1  <= id1;
        end
    end

    // Stage p1: steer SRAM read data to the tagged requester; both tags never share an id.
    always_comb begin
        RSP_VALID = '0;
        RSP_Q     = '0;
        if (vld0_p1) begin
            RSP_VALID[id0_p1]              = 1'b1;
            RSP_Q[int'(id0_p1)*DW +: DW]   = Q0;
        end
        if (vld1_p1) begin
            RSP_VALID[id1_p1]              = 1'b1;
            RSP_Q[int'(id1_p1)*DW +: DW]   = Q1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset corner sequences,
// with a behavioural dual-port SRAM (1-cycle read latency, masked writes).
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
    logic [15:0] REQ_ADDR;
    logic [63:0] REQ_D, REQ_WEM, RSP_Q;
    logic [3:0]  A0, A1;
    logic [15:0] D0, D1, WEM0, WEM1;
    logic        WE0, WE1, CE0, CE1;
    logic [15:0] Q0 = '0;
    logic [15:0] Q1 = '0;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [16] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                              16'h1004, 16'h0000, 16'h1006, 16'h1234,
                              16'h1008, 16'h1111, 16'h100A, 16'h100B,
                              16'h100C, 16'h100D, 16'h100E, 16'h100F};

    mem_port_arbiter #(.NREQ(4), .AW(4), .DW(16)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_D(REQ_D), .REQ_WEM(REQ_WEM),
        .RSP_VALID(RSP_VALID), .RSP_Q(RSP_Q),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
        .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
            else     Q0 <= mem[A0];
        end
        if (CE1) begin
            if (WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
            else     Q1 <= mem[A1];
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [63:0] d;
        logic [63:0] wem;
        logic [3:0]  ready;
        logic [1:0]  ce;   // {CE1, CE0}
        logic [1:0]  wex;  // {WE1, WE0}
        logic [3:0]  rv;
        logic [63:0] rq;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic [3:0] valid, logic [3:0] we, logic [15:0] addr,
                                logic [63:0] d, logic [63:0] wem, logic [3:0] ready,
                                logic [1:0] ce, logic [1:0] wex, logic [3:0] rv,
                                logic [63:0] rq);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.d = d; v.wem = wem;
        v.ready = ready; v.ce = ce; v.wex = wex; v.rv = rv; v.rq = rq;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h, want %h", name, step, act, exp);
        end
    endtask

    initial begin
        // Round robin over all four readers, then write/read hazard, then shared read.
        tbl[0]  = mk(4'b1111, 4'b0000, 16'h4321, '0, '0, 4'b0011, 2'b11, 2'b00, 4'b0011, 64'h0000_0000_1002_1001);
        tbl[1]  = mk(4'b1111, 4'b0000, 16'h4321, '0, '0, 4'b1100, 2'b11, 2'b00, 4'b1100, 64'h1004_1003_0000_0000);
        tbl[2]  = mk(4'b1111, 4'b0000, 16'h4321, '0, '0, 4'b0011, 2'b11, 2'b00, 4'b0011, 64'h0000_0000_1002_1001);
        tbl[3]  = mk(4'b0011, 4'b0001, 16'h0055, 64'h0000_0000_0000_A5A5, 64'h0000_0000_0000_FFFF,
                     4'b0001, 2'b01, 2'b01, 4'b0000, 64'h0);
        tbl[4]  = mk(4'b0010, 4'b0000, 16'h0050, '0, '0, 4'b0010, 2'b01, 2'b00, 4'b0010, 64'h0000_0000_A5A5_0000);
        tbl[5]  = mk(4'b1100, 4'b0000, 16'h7700, '0, '0, 4'b1100, 2'b11, 2'b00, 4'b1100, 64'h1234_1234_0000_0000);
        tbl[6]  = mk(4'b1000, 4'b0000, 16'h3000, '0, '0, 4'b1000, 2'b01, 2'b00, 4'b1000, 64'h1003_0000_0000_0000);
        tbl[7]  = mk(4'b1111, 4'b0000, 16'h4321, '0, '0, 4'b0011, 2'b11, 2'b00, 4'b0011, 64'h0000_0000_1002_1001);
        tbl[8]  = mk(4'b0100, 4'b0100, 16'h0900, 64'h0000_BEEF_0000_0000, 64'h0000_00FF_0000_0000,
                     4'b0100, 2'b01, 2'b01, 4'b0000, 64'h0);
        tbl[9]  = mk(4'b0100, 4'b0000, 16'h0900, '0, '0, 4'b0100, 2'b01, 2'b00, 4'b0100, 64'h0000_11EF_0000_0000);
        tbl[10] = mk(4'b0000, 4'b0000, 16'h0000, '0, '0, 4'b0000, 2'b00, 2'b00, 4'b0000, 64'h0);
        tbl[11] = mk(4'b1111, 4'b1000, 16'h6866, 64'h5555_0000_0000_0000, 64'hFFFF_0000_0000_0000,
                     4'b1100, 2'b11, 2'b01, 4'b0100, 64'h0000_1008_0000_0000);
        tbl[12] = mk(4'b0001, 4'b0000, 16'h0006, '0, '0, 4'b0001, 2'b01, 2'b00, 4'b0001, 64'h0000_0000_0000_5555);

        RSTN = 1'b0; REQ_VALID = 4'b1111; REQ_WE = '0; REQ_ADDR = 16'h4321;
        REQ_D = '0; REQ_WEM = '0;
        #2;
        check("rst_ready", -1, 64'(REQ_READY), 64'h0);
        check("rst_ce", -1, 64'({CE1, CE0}), 64'h0);
        check("rst_we", -1, 64'({WE1, WE0}), 64'h0);
        check("rst_rsp_valid", -1, 64'(RSP_VALID), 64'h0);
        check("rst_rsp_q", -1, RSP_Q, 64'h0);
        @(negedge CLK); @(negedge CLK);
        RSTN = 1'b1; REQ_VALID = '0;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            REQ_VALID = tbl[i].valid; REQ_WE = tbl[i].we; REQ_ADDR = tbl[i].addr;
            REQ_D = tbl[i].d; REQ_WEM = tbl[i].wem;
            #1;
            check("ready", i, 64'(REQ_READY), 64'(tbl[i].ready));
            check("ce", i, 64'({CE1, CE0}), 64'(tbl[i].ce));
            check("we", i, 64'({WE1, WE0}), 64'(tbl[i].wex));
            @(posedge CLK); #1;
            check("rsp_valid", i, 64'(RSP_VALID), 64'(tbl[i].rv));
            check("rsp_q", i, RSP_Q, tbl[i].rq);
        end

        // Reset asserted right after a read grant drops the response.
        @(negedge CLK);
        REQ_VALID = 4'b0001; REQ_WE = '0; REQ_ADDR = 16'h0002; REQ_D = '0; REQ_WEM = '0;
        #1;
        check("pre_rst_ready", 100, 64'(REQ_READY), 64'h1);
        @(posedge CLK); #1;
        RSTN = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 101, 64'(RSP_VALID), 64'h0);
        check("mid_rst_rsp_q", 101, RSP_Q, 64'h0);
        check("mid_rst_ready", 101, 64'(REQ_READY), 64'h0);
        check("mid_rst_ce", 101, 64'({CE1, CE0}), 64'h0);
        @(posedge CLK); #1;
        check("hold_rst_rsp_valid", 102, 64'(RSP_VALID), 64'h0);
        @(negedge CLK);
        RSTN = 1'b1; REQ_VALID = '0;
        @(posedge CLK); #1;
        check("post_rst_rsp_valid", 103, 64'(RSP_VALID), 64'h0);
        check("post_rst_ce", 103, 64'({CE1, CE0}), 64'h0);
        check("post_rst_we", 103, 64'({WE1, WE0}), 64'h0);
        @(negedge CLK);
        REQ_VALID = 4'b1111; REQ_ADDR = 16'h4321;
        #1;
        check("post_rst_ptr0_ready", 104, 64'(REQ_READY), 64'h3);
        @(posedge CLK); #1;
        check("post_rst_rsp_q", 104, RSP_Q, 64'h0000_0000_1002_1001);
        @(negedge CLK);
        REQ_VALID = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
